// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo controller.
package uart_echo_pkg;

  localparam int DATA_W              = 8;
  localparam int TX_ACK_TIMEOUT_DFLT = 16;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_WAIT = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_WRITE = 2'd1,
    T_ACK   = 2'd2
  } tx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// Synchronous byte FIFO, write-to-read latency 1 cycle; head is combinational from the read pointer.
// Push while full is accepted only when a pop happens on the same edge; pop while empty is ignored.
module echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [DATA_W-1:0]      i_dat,
  output logic [DATA_W-1:0]      o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic              w_wr;
  logic              w_rd;

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_level <= r_level + (AW+1)'(1);
      else if (w_rd && !w_wr) r_level <= r_level - (AW+1)'(1);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echoes CoreUART RX bytes back to TX through a small FIFO; rxrdy-to-wen latency 3 edges, all outputs registered.
// Bytes arriving while the FIFO is full (and not popping) are dropped and counted; TX waits for txrdy with a timeout.
module uart_echo_ctrl
  import uart_echo_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TX_ACK_TIMEOUT = TX_ACK_TIMEOUT_DFLT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rxrdy,
  input  logic [DATA_W-1:0]           data_out,
  output logic                        oen,
  input  logic                        txrdy,
  output logic                        wen,
  output logic [DATA_W-1:0]           data_in,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  drop_count,
  output logic                        tx_err,
  output logic [15:0]                 rx_count,
  output logic [15:0]                 tx_count
);

  localparam int TO_W = $clog2(TX_ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_ACK_TIMEOUT - 1);

  rx_state_t r_rx_state, w_rx_nxt;
  tx_state_t r_tx_state, w_tx_nxt;

  logic              r_oen, w_oen_nxt;
  logic              r_wen, w_wen_nxt;
  logic [DATA_W-1:0] r_data_in;
  logic [TO_W-1:0]   r_to_cnt;
  logic [15:0]       r_rx_count;
  logic [15:0]       r_tx_count;
  logic [7:0]        r_drop_count;
  logic              r_overflow;
  logic              r_tx_err;

  logic              w_push;
  logic              w_pop;
  logic              w_tx_err_set;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  echo_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (data_out),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // A full FIFO still accepts the byte if TX frees a slot on the same edge.
  assign w_push = (r_rx_state == R_READ) && (!w_full || w_pop);

  always_comb begin
    w_rx_nxt  = r_rx_state;
    w_oen_nxt = 1'b1;
    case (r_rx_state)
      R_IDLE: if (rxrdy) begin
        w_rx_nxt  = R_READ;
        w_oen_nxt = 1'b0;
      end
      R_READ:  w_rx_nxt = R_WAIT;
      R_WAIT:  if (!rxrdy) w_rx_nxt = R_IDLE;
      default: w_rx_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_tx_nxt     = r_tx_state;
    w_wen_nxt    = 1'b1;
    w_pop        = 1'b0;
    w_tx_err_set = 1'b0;
    case (r_tx_state)
      T_IDLE: if (!w_empty && txrdy) begin
        w_tx_nxt  = T_WRITE;
        w_wen_nxt = 1'b0;
        w_pop     = 1'b1;
      end
      T_WRITE: w_tx_nxt = T_ACK;
      T_ACK: begin
        if (!txrdy) begin
          w_tx_nxt = T_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_tx_nxt     = T_IDLE;
          w_tx_err_set = 1'b1;
        end
      end
      default: w_tx_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
      r_tx_state <= T_IDLE;
      r_oen      <= 1'b1;
      r_wen      <= 1'b1;
    end else begin
      r_rx_state <= w_rx_nxt;
      r_tx_state <= w_tx_nxt;
      r_oen      <= w_oen_nxt;
      r_wen      <= w_wen_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_in    <= '0;
      r_to_cnt     <= '0;
      r_rx_count   <= '0;
      r_tx_count   <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
      r_tx_err     <= 1'b0;
    end else begin
      if (w_pop) r_data_in <= w_head;
      if (r_tx_state == T_WRITE) begin
        r_to_cnt   <= '0;
        r_tx_count <= r_tx_count + 16'd1;
      end else if (r_tx_state == T_ACK) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_tx_err_set) r_tx_err <= 1'b1;
      if (r_rx_state == R_READ) begin
        r_rx_count <= r_rx_count + 16'd1;
        if (!w_push) begin
          r_overflow   <= 1'b1;
          r_drop_count <= sat_inc8(r_drop_count);
        end
      end
    end
  end

  assign oen        = r_oen;
  assign wen        = r_wen;
  assign data_in    = r_data_in;
  assign fifo_level = w_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign tx_err     = r_tx_err;
  assign rx_count   = r_rx_count;
  assign tx_count   = r_tx_count;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Bench for uart_echo_ctrl: a CoreUART-like stub on both sides, directed phases plus a randomized echo run.
module tb_uart_echo_ctrl;

  localparam int DEPTH     = 8;
  localparam int TMO       = 16;
  localparam int TXM_AUTO  = 0;
  localparam int TXM_HOLD  = 1;
  localparam int TXM_STUCK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxrdy;
  logic [7:0]  data_out;
  logic        oen;
  logic        txrdy;
  logic        wen;
  logic [7:0]  data_in;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        tx_err;
  logic [15:0] rx_count;
  logic [15:0] tx_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int oen_pulses, wen_pulses, rise_cyc, oen_cyc, first_wen_cyc, err_cyc;
  int rx_gap, rx_gmin, rx_gmax, tx_ack, tx_mode;
  int m_rx, m_tx;
  logic [7:0] rx_src[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] nb;

  always #5 clk = ~clk;

  uart_echo_ctrl #(.FIFO_DEPTH(DEPTH), .TX_ACK_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxrdy      (rxrdy),
    .data_out   (data_out),
    .oen        (oen),
    .txrdy      (txrdy),
    .wen        (wen),
    .data_in    (data_in),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .tx_err     (tx_err),
    .rx_count   (rx_count),
    .tx_count   (tx_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_miss++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  // One clock of UART stub behaviour, evaluated at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (oen === 1'b0) begin
      oen_pulses++;
      oen_cyc = cyc;
      rxrdy   = 1'b0;
      rx_gap  = int'($urandom_range(rx_gmax, rx_gmin));
    end else if (rxrdy === 1'b0) begin
      if (rx_gap > 0) rx_gap--;
      else if (rx_src.size() > 0) begin
        data_out = rx_src.pop_front();
        rxrdy    = 1'b1;
        rise_cyc = cyc;
      end
    end
    if (wen === 1'b0) begin
      if (wen_pulses == 0) first_wen_cyc = cyc;
      wen_pulses++;
      got.push_back(data_in);
      if (tx_mode == TXM_AUTO) begin
        txrdy  = 1'b0;
        tx_ack = int'($urandom_range(3, 2));
      end
    end else if (tx_mode == TXM_AUTO && txrdy === 1'b0) begin
      if (tx_ack > 1) tx_ack--;
      else txrdy = 1'b1;
    end
    if (tx_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    oen_pulses    = 0;
    wen_pulses    = 0;
    rise_cyc      = -1;
    oen_cyc       = -1;
    first_wen_cyc = -1;
    err_cyc       = -1;
    got.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    rx_src.push_back(b);
    m_rx++;
    if (keep) begin
      exp_q.push_back(b);
      m_tx++;
    end
  endtask

  initial begin
    rst_n = 1'b0; rxrdy = 1'b0; txrdy = 1'b1; data_out = 8'h00;
    tx_mode = TXM_AUTO; rx_gap = 0; tx_ack = 0; rx_gmin = 1; rx_gmax = 2;
    m_rx = 0; m_tx = 0;
    clr();
    run(3);
    check("rst_oen", 32'(oen), 1);
    check("rst_wen", 32'(wen), 1);
    check("rst_data_in", 32'(data_in), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_flags", {30'd0, overflow, tx_err}, 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_counts", {rx_count, tx_count}, 0);
    rst_n = 1'b1;
    run(2);

    // single byte with latency measurement
    clr();
    send(8'hA5, 1'b1);
    run(30);
    check("single_oen_pulses", oen_pulses, 1);
    check("single_wen_pulses", wen_pulses, 1);
    check("single_oen_lat", oen_cyc - rise_cyc, 1);
    check("single_echo_lat", first_wen_cyc - rise_cyc, 3);
    check_stream("single");
    check("single_rx_count", 32'(rx_count), m_rx);
    check("single_tx_count", 32'(tx_count), m_tx);
    check("single_data_hold", 32'(data_in), 32'h A5);

    // burst held off by txrdy, then released
    clr();
    tx_mode = TXM_HOLD; txrdy = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    run(40);
    check("burst_level", 32'(fifo_level), 5);
    check("burst_no_wen", wen_pulses, 0);
    check("burst_oen_pulses", oen_pulses, 5);
    tx_mode = TXM_AUTO; txrdy = 1'b1;
    run(40);
    check_stream("burst");
    check("burst_level_end", 32'(fifo_level), 0);
    check("burst_rx_count", 32'(rx_count), m_rx);
    check("burst_tx_count", 32'(tx_count), m_tx);

    // overflow: DEPTH+3 bytes with no transmit
    clr();
    tx_mode = TXM_HOLD; txrdy = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) send(8'($urandom_range(255, 0)), i < DEPTH);
    run(80);
    check("ovf_level", 32'(fifo_level), DEPTH);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drop", 32'(drop_count), 3);
    check("ovf_rx_count", 32'(rx_count), m_rx);
    check("ovf_no_wen", wen_pulses, 0);

    // full FIFO: pop lines up with the read cycle, byte is kept
    nb = 8'($urandom_range(255, 0));
    rx_gap = 0;
    send(nb, 1'b1);
    tick();
    tick();
    tx_mode = TXM_AUTO; txrdy = 1'b1;
    tick();
    check("cpop_level", 32'(fifo_level), DEPTH);
    check("cpop_drop", 32'(drop_count), 3);
    run(80);
    check_stream("cpop");
    check("cpop_level_end", 32'(fifo_level), 0);
    check("cpop_sticky", 32'(overflow), 1);
    check("cpop_tx_count", 32'(tx_count), m_tx);

    // transmit acknowledge timeout
    clr();
    tx_mode = TXM_STUCK; txrdy = 1'b1;
    send(8'h3C, 1'b1);
    send(8'hC3, 1'b1);
    run(80);
    check("tmo_flag", 32'(tx_err), 1);
    check("tmo_timing", err_cyc - first_wen_cyc, TMO + 1);
    check_stream("tmo");

    // reset while bytes are buffered and a write strobe is active
    clr();
    tx_mode = TXM_HOLD; txrdy = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h50 + 8'(i), 1'b1);
    run(30);
    check("mrst_pre_level", 32'(fifo_level), 3);
    tx_mode = TXM_STUCK; txrdy = 1'b1;
    tick();
    check("mrst_pre_wen", 32'(wen), 0);
    rst_n = 1'b0;
    #1;
    check("mrst_wen", 32'(wen), 1);
    check("mrst_oen", 32'(oen), 1);
    check("mrst_level", 32'(fifo_level), 0);
    check("mrst_counts", {rx_count, tx_count}, 0);
    check("mrst_flags", {22'd0, drop_count, overflow, tx_err}, 0);
    rx_src.delete();
    m_rx = 0; m_tx = 0;
    clr();
    tx_mode = TXM_AUTO; txrdy = 1'b1;
    run(3);
    rst_n = 1'b1;
    run(40);
    check("mrst_no_stale", wen_pulses, 0);
    check("mrst_tx_count", 32'(tx_count), 0);

    // randomized echo traffic, paced so the FIFO never fills
    clr();
    rx_gmin = 3; rx_gmax = 8;
    for (int i = 0; i < 40; i++) send(8'($urandom_range(255, 0)), 1'b1);
    for (int k = 0; k < 3000 && got.size() < 40; k++) tick();
    run(10);
    check_stream("rand");
    check("rand_drop", 32'(drop_count), 0);
    check("rand_rx_count", 32'(rx_count), m_rx);
    check("rand_tx_count", 32'(tx_count), m_tx);
    check("rand_tx_err", 32'(tx_err), 0);
    check("rand_level", 32'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
